// File: rtl/ps2_mouse_pkg.sv
// Command/reply byte values and FSM state encoding shared by the PS/2 mouse
// bring-up sequencer and its command ROM.
package ps2_mouse_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERROR    = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_ID   = 8'h00;
  localparam logic [7:0] ID_WHEEL     = 8'h03;

  localparam int         CMD_IDX_W    = 4;
  localparam logic [1:0] MAX_RESENDS  = 2'd2;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_PULSE,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_DONE,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/ps2_mouse_cmd_rom.sv
// Combinational command list for mouse bring-up, indexed by cmd_idx.
// MOUSE_WHEEL_EN inserts the F3 C8 / F3 64 / F3 50 / F2 wheel knock after the reset.
module ps2_mouse_cmd_rom
  import ps2_mouse_pkg::*;
#(
  parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
  input  logic [CMD_IDX_W-1:0] cmd_idx,
  output logic [7:0]           cmd_byte,
  output logic                 is_last,
  output logic                 expect_bat,
  output logic                 expect_id
);

  always_comb begin
    cmd_byte   = CMD_RESET;
    is_last    = 1'b0;
    expect_bat = 1'b0;
    expect_id  = 1'b0;
    case (cmd_idx)
`ifdef MOUSE_WHEEL_EN
      4'd0:  begin cmd_byte = CMD_RESET; expect_bat = 1'b1; end
      4'd1:  cmd_byte = CMD_SET_RATE;
      4'd2:  cmd_byte = 8'd200;
      4'd3:  cmd_byte = CMD_SET_RATE;
      4'd4:  cmd_byte = 8'd100;
      4'd5:  cmd_byte = CMD_SET_RATE;
      4'd6:  cmd_byte = 8'd80;
      4'd7:  begin cmd_byte = CMD_GET_ID; expect_id = 1'b1; end
      4'd8:  cmd_byte = CMD_SET_RATE;
      4'd9:  cmd_byte = SAMPLE_RATE;
      4'd10: begin cmd_byte = CMD_ENABLE; is_last = 1'b1; end
`else
      4'd0:  begin cmd_byte = CMD_RESET; expect_bat = 1'b1; end
      4'd1:  cmd_byte = CMD_SET_RATE;
      4'd2:  cmd_byte = SAMPLE_RATE;
      4'd3:  begin cmd_byte = CMD_ENABLE; is_last = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse bring-up: sends the command list, checks ACK/BAT/ID replies, retries, then hands off.
// MOUSE_WHEEL_EN compiles in the wheel knock, the ID wait state and the wheel flag.
module ps2_mouse_init_sequencer
  import ps2_mouse_pkg::*;
#(
  parameter logic [7:0]  SAMPLE_RATE = 8'd100,
  parameter logic [31:0] ACK_TIMEOUT = 32'd1_000_000,
  parameter logic [31:0] BAT_TIMEOUT = 32'd30_000_000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  output logic [7:0] tx_data,
  output logic       tx_load,
  input  logic       tx_busy,
  input  logic       tx_error,
  output logic       rx_enable,
  input  logic       rx_strobe,
  input  logic [7:0] rx_byte,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retries,
  output logic       wheel
);

  localparam logic [1:0] MAX_R = 2'(MAX_RETRIES);

  state_e                 state_q, state_d;
  logic [CMD_IDX_W-1:0]   cmd_idx_q, cmd_idx_d;
  logic [31:0]            timer_q, timer_d;
  logic [1:0]             resend_q, resend_d;
  logic                   bat_phase_q, bat_phase_d;
  logic                   tx_first_q, tx_first_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_load_q, tx_load_d;
  logic                   rx_enable_q, rx_enable_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic [1:0]             retries_q, retries_d;
  logic                   wheel_q, wheel_d;

  logic [7:0] rom_byte;
  logic       rom_last, rom_bat, rom_id;
  logic       failure, accepted, ack_to, bat_to;

  ps2_mouse_cmd_rom #(.SAMPLE_RATE(SAMPLE_RATE)) u_rom (
    .cmd_idx    (cmd_idx_q),
    .cmd_byte   (rom_byte),
    .is_last    (rom_last),
    .expect_bat (rom_bat),
    .expect_id  (rom_id)
  );

  always_comb begin
    state_d     = state_q;
    cmd_idx_d   = cmd_idx_q;
    resend_d    = resend_q;
    bat_phase_d = bat_phase_q;
    tx_first_d  = tx_first_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    rx_enable_d = rx_enable_q;
    ready_d     = ready_q;
    fail_d      = fail_q;
    retries_d   = retries_q;
    wheel_d     = wheel_q;
    failure     = 1'b0;
    accepted    = 1'b0;
    ack_to      = (timer_q >= ACK_TIMEOUT);
    bat_to      = (timer_q >= BAT_TIMEOUT);

    case (state_q)
      ST_LOAD: begin
        rx_enable_d = 1'b0;
        // A transfer abandoned by restart/reset must drain before the next load.
        if (!tx_busy) begin
          tx_data_d = rom_byte;
          state_d   = ST_PULSE;
        end
      end
      ST_PULSE: begin
        tx_load_d  = 1'b1;
        tx_first_d = 1'b1;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_error) begin
          failure = 1'b1;
        end else if (tx_first_q) begin
          tx_first_d = 1'b0;
        end else if (!tx_busy) begin
          rx_enable_d = 1'b1;
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (rx_strobe) begin
          accepted = 1'b1;
          if (rx_byte == RSP_ACK) begin
            cmd_idx_d = cmd_idx_q + 1'b1;
            resend_d  = 2'd0;
            if (rom_bat) begin
              bat_phase_d = 1'b0;
              state_d     = ST_WAIT_BAT;
`ifdef MOUSE_WHEEL_EN
            end else if (rom_id) begin
              state_d = ST_WAIT_ID;
`endif
            end else if (rom_last) begin
              ready_d = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOAD;
            end
          end else if (rx_byte == RSP_RESEND && resend_q != MAX_RESENDS) begin
            resend_d = resend_q + 2'd1;
            state_d  = ST_LOAD;
          end else begin
            failure = 1'b1;
          end
        end else if (ack_to) begin
          failure = 1'b1;
        end
      end
      ST_WAIT_BAT: begin
        if (rx_strobe) begin
          accepted = 1'b1;
          if (!bat_phase_q && rx_byte == RSP_BAT_OK) begin
            bat_phase_d = 1'b1;
          end else if (bat_phase_q && rx_byte == RSP_BAT_ID) begin
            state_d = ST_LOAD;
          end else begin
            failure = 1'b1;
          end
        end else if (bat_to) begin
          failure = 1'b1;
        end
      end
`ifdef MOUSE_WHEEL_EN
      ST_WAIT_ID: begin
        if (rx_strobe) begin
          accepted = 1'b1;
          wheel_d  = (rx_byte == ID_WHEEL);
          state_d  = ST_LOAD;
        end else if (ack_to) begin
          failure = 1'b1;
        end
      end
`endif
      ST_DONE: rx_enable_d = 1'b1;
      ST_FAIL: rx_enable_d = 1'b1;
      default: state_d = ST_LOAD;
    endcase

    if (failure) begin
      resend_d  = 2'd0;
      cmd_idx_d = '0;
      if (retries_q < MAX_R) begin
        retries_d = retries_q + 2'd1;
        state_d   = ST_LOAD;
      end else begin
        fail_d      = 1'b1;
        rx_enable_d = 1'b1;
        state_d     = ST_FAIL;
      end
    end

    if (restart) begin
      state_d   = ST_LOAD;
      cmd_idx_d = '0;
      resend_d  = 2'd0;
      retries_d = 2'd0;
      ready_d   = 1'b0;
      fail_d    = 1'b0;
      wheel_d   = 1'b0;
      tx_load_d = 1'b0;
    end

    if (state_d != state_q || accepted || restart)
      timer_d = '0;
    else if (timer_q != '1)
      timer_d = timer_q + 32'd1;
    else
      timer_d = timer_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      cmd_idx_q   <= '0;
      timer_q     <= '0;
      resend_q    <= 2'd0;
      bat_phase_q <= 1'b0;
      tx_first_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_load_q   <= 1'b0;
      rx_enable_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      retries_q   <= 2'd0;
      wheel_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_idx_q   <= cmd_idx_d;
      timer_q     <= timer_d;
      resend_q    <= resend_d;
      bat_phase_q <= bat_phase_d;
      tx_first_q  <= tx_first_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      rx_enable_q <= rx_enable_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      retries_q   <= retries_d;
      wheel_q     <= wheel_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_load   = tx_load_q;
  assign rx_enable = rx_enable_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retries   = retries_q;
`ifdef MOUSE_WHEEL_EN
  assign wheel     = wheel_q;
`else
  // Without the knock sequence the ROM never flags an ID byte.
  logic unused_id;
  assign unused_id = rom_id ^ wheel_q;
  assign wheel     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Bench for ps2_mouse_init_sequencer: a PS/2 device model answers each transmitted byte
// under a per-vector reply policy; expected transmit bytes are queued and checked on each load.
module tb_ps2_mouse_init_sequencer;

  localparam logic [31:0] ACK_TO = 32'd200;
  localparam logic [31:0] BAT_TO = 32'd500;
  localparam int          TX_CYC = 10;
  localparam int          GAP    = 5;
`ifdef MOUSE_WHEEL_EN
  localparam bit WHEEL_BUILD = 1'b1;
`else
  localparam bit WHEEL_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_error = 1'b0;
  logic       rx_strobe = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_data;
  logic       tx_load, rx_enable, ready, fail, wheel;
  logic [1:0] retries;

  ps2_mouse_init_sequencer #(
    .SAMPLE_RATE (8'd100),
    .ACK_TIMEOUT (ACK_TO),
    .BAT_TIMEOUT (BAT_TO),
    .MAX_RETRIES (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_busy   (tx_busy),
    .tx_error  (tx_error),
    .rx_enable (rx_enable),
    .rx_strobe (rx_strobe),
    .rx_byte   (rx_byte),
    .ready     (ready),
    .fail      (fail),
    .retries   (retries),
    .wheel     (wheel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         silent;
    bit         fe_en;
    bit         fc_en;
    logic [7:0] id;
    bit         exp_ready;
    bit         exp_fail;
    logic [1:0] exp_retries;
    bit         exp_wheel;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         epoch = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cmd_list[$];
  vec_t       vecs[6];

  bit         pol_silent = 1'b0;
  int         pol_fe_left = 0;
  int         pol_fc_left = 0;
  bit         pol_stall_en = 1'b0;
  logic [7:0] pol_id = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, bit sil, bit fe, bit fc, logic [7:0] id,
                              bit er, bit ef, logic [1:0] ert, bit ew);
    vec_t v;
    v.name = nm; v.silent = sil; v.fe_en = fe; v.fc_en = fc; v.id = id;
    v.exp_ready = er; v.exp_fail = ef; v.exp_retries = ert; v.exp_wheel = ew;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int e, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < GAP; i++) begin
      @(negedge clk);
      if (epoch != e) return;
    end
    rx_byte = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
    ok = (epoch == e);
  endtask

  task automatic respond(input logic [7:0] b, input int e);
    bit ok;
    if (pol_silent || (pol_stall_en && b == 8'hF3)) return;
    if (pol_fe_left > 0 && b == 8'hF3) begin
      pol_fe_left--;
      send_byte(8'hFE, e, ok);
      return;
    end
    if (pol_fc_left > 0 && b == 8'hF4) begin
      pol_fc_left--;
      send_byte(8'hFC, e, ok);
      return;
    end
    send_byte(8'hFA, e, ok);
    if (ok && b == 8'hFF) begin
      send_byte(8'hAA, e, ok);
      if (ok) send_byte(8'h00, e, ok);
    end
    if (ok && b == 8'hF2) send_byte(pol_id, e, ok);
  endtask

  // Device model: accept each load, hold busy, then reply per the active policy.
  initial begin : dev_model
    logic [7:0] b;
    int e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_load) begin
        b = tx_data;
        e = epoch;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got %02h want no transmit", b);
        end else begin
          chk("tx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
        tx_busy = 1'b1;
        for (int i = 0; i < TX_CYC; i++) begin
          @(negedge clk);
          if (i == 0) chk("tx_load_width", 32'(tx_load), 32'd0);
          else if (tx_load) begin
            total++; bad++;
            $display("FAIL load_while_busy: got tx_load=1 want 0");
          end
          if (i == TX_CYC - 1 && epoch == e) chk("tx_data_hold", 32'(tx_data), 32'(b));
        end
        tx_busy = 1'b0;
        if (epoch == e) respond(b, e);
      end
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk(nm, 32'({tx_data, tx_load, rx_enable, ready, fail, retries, wheel}),
            32'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}));
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    epoch++;
    for (int c = 0; c < 200 && tx_busy; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk_reset_vals("reset_vals");
    exp_q.delete();
  endtask

  task automatic reset_release();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_load_early", 32'(tx_load), 32'd0);
    @(negedge clk);
    chk("first_load_at2", 32'(tx_load), 32'd1);
  endtask

  task automatic set_policy(input vec_t v);
    pol_silent   = v.silent;
    pol_fe_left  = v.fe_en ? 1 : 0;
    pol_fc_left  = v.fc_en ? 1 : 0;
    pol_id       = v.id;
    pol_stall_en = 1'b0;
  endtask

  task automatic push_expected(input vec_t v);
    bit fe_done = 1'b0;
    if (v.silent) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
      return;
    end
    if (v.fc_en) begin
      for (int i = 0; i < cmd_list.size(); i++) begin
        exp_q.push_back(cmd_list[i]);
        if (cmd_list[i] == 8'hF4) break;
      end
    end
    for (int i = 0; i < cmd_list.size(); i++) begin
      exp_q.push_back(cmd_list[i]);
      if (v.fe_en && !fe_done && cmd_list[i] == 8'hF3) begin
        exp_q.push_back(cmd_list[i]);
        fe_done = 1'b1;
      end
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 20000; c++) begin
      if (ready || fail) break;
      @(negedge clk);
    end
    chk("finished", 32'(ready | fail), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_sb_empty(input string nm);
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(negedge clk);
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : main
    vec_t v;
    if (WHEEL_BUILD)
      cmd_list = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF3, 8'h64, 8'hF4};
    else
      cmd_list = '{8'hFF, 8'hF3, 8'h64, 8'hF4};

    vecs[0] = mk("normal",    0, 0, 0, 8'h00, 1, 0, 2'd0, 0);
    vecs[1] = mk("resend",    0, 1, 0, 8'h00, 1, 0, 2'd0, 0);
    vecs[2] = mk("silent",    1, 0, 0, 8'h00, 0, 1, 2'd3, 0);
    vecs[3] = mk("error_f4",  0, 0, 1, 8'h00, 1, 0, 2'd1, 0);
    vecs[4] = mk("wheel_id3", 0, 0, 0, 8'h03, 1, 0, 2'd0, WHEEL_BUILD);
    vecs[5] = mk("wheel_id0", 0, 0, 0, 8'h00, 1, 0, 2'd0, 0);

    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      reset_assert();
      set_policy(v);
      push_expected(v);
      reset_release();
      wait_done();
      chk({v.name, "_ready"},   32'(ready),   32'(v.exp_ready));
      chk({v.name, "_fail"},    32'(fail),    32'(v.exp_fail));
      chk({v.name, "_retries"}, 32'(retries), 32'(v.exp_retries));
      chk({v.name, "_wheel"},   32'(wheel),   32'(v.exp_wheel));
      chk({v.name, "_rx_en"},   32'(rx_enable), 32'd1);
      chk({v.name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      if (v.silent) begin
        exp_q.push_back(8'hFF);
        restart = 1'b1;
        epoch++;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_fail_clr",    32'(fail),    32'd0);
        chk("restart_retries_clr", 32'(retries), 32'd0);
        wait_sb_empty("restart_tx_ff");
      end
    end

    // Reset while waiting for the F3 acknowledge.
    reset_assert();
    set_policy(vecs[0]);
    pol_stall_en = 1'b1;
    exp_q.push_back(cmd_list[0]);
    exp_q.push_back(cmd_list[1]);
    reset_release();
    wait_sb_empty("stall_reach_f3");
    for (int c = 0; c < 100 && tx_busy; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("wait_ack_rx_en", 32'(rx_enable), 32'd1);
    rst_n = 1'b0;
    epoch++;
    @(negedge clk);
    chk_reset_vals("midseq_reset_vals");
    @(negedge clk);
    pol_stall_en = 1'b0;
    push_expected(vecs[0]);
    reset_release();
    wait_done();
    chk("midseq_ready",   32'(ready),   32'd1);
    chk("midseq_retries", 32'(retries), 32'd0);
    chk("midseq_sb",      32'(exp_q.size()), 32'd0);

    // Restart while the transmitter is still busy with F3.
    reset_assert();
    set_policy(vecs[0]);
    exp_q.push_back(cmd_list[0]);
    exp_q.push_back(cmd_list[1]);
    reset_release();
    wait_sb_empty("busy_reach_f3");
    @(negedge clk);
    chk("busy_before_restart", 32'(tx_busy), 32'd1);
    restart = 1'b1;
    epoch++;
    @(negedge clk);
    restart = 1'b0;
    push_expected(vecs[0]);
    wait_done();
    chk("busy_restart_ready",   32'(ready),   32'd1);
    chk("busy_restart_retries", 32'(retries), 32'd0);
    chk("busy_restart_sb",      32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
